// File: rtl/bus_grant_ctrl.sv
// bus_grant_ctrl: round-robin owner sequencer for the shared 8-bit data bus.
// Drives one-hot (or all-off) enables to the per-source tri-state buffers and
// always inserts one all-off turnaround cycle between owners.
// Optional build macro BUS_GRANT_TIMEOUT_EN: limits each grant to HOLD_MAX
// cycles and pulses o_timeout on a forced release. Without it the owner keeps
// the bus for as long as its request is held and o_timeout is tied low.
module bus_grant_ctrl #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 8,
    parameter int OWN_W    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NREQ-1:0]  i_req,
    output logic [NREQ-1:0]  o_en,
    output logic [OWN_W-1:0] o_owner,
    output logic             o_busy,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [NREQ-1:0]  r_en, w_en_nxt;
    logic [OWN_W-1:0] r_owner, w_owner_nxt;
    logic [OWN_W-1:0] r_last, w_last_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [OWN_W-1:0] w_win, w_hi_win, w_lo_win;
    logic             w_any, w_hi_any, w_lo_any;
    logic             w_own_req;
    logic             w_hold_done;

    // The owner's request is found through its own enable bit, so no
    // variable index into i_req is needed.
    assign w_own_req = |(i_req & r_en);

    // Round-robin pick: lowest requester above r_last wins, else lowest overall
    // (wrap). A released owner therefore lands at the back of the queue.
    always_comb begin
        w_hi_win = '0;
        w_hi_any = 1'b0;
        w_lo_win = '0;
        w_lo_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                if (k > int'(r_last)) begin
                    w_hi_any = 1'b1;
                    w_hi_win = OWN_W'(k);
                end else begin
                    w_lo_any = 1'b1;
                    w_lo_win = OWN_W'(k);
                end
            end
        end
        w_any = w_hi_any | w_lo_any;
        w_win = w_hi_any ? w_hi_win : w_lo_win;
    end

`ifdef BUS_GRANT_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    // Release is forced once the counter reaches HOLD_MAX-1, so it never wraps.
    assign w_hold_done = (r_cnt == CNT_W'(HOLD_MAX - 1));

    // Counter restarts on every new grant and advances while the owner stays.
    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == S_GRANT && w_state_nxt == S_GRANT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    assign w_hold_done = 1'b0;
`endif

    // Next-state and registered-output logic; hold everything by default.
    always_comb begin
        w_state_nxt   = r_state;
        w_en_nxt      = r_en;
        w_owner_nxt   = r_owner;
        w_busy_nxt    = r_busy;
        w_last_nxt    = r_last;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_en_nxt    = NREQ'(1) << w_win;
                    w_owner_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_en_nxt    = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_GRANT: begin
                // Voluntary release takes priority over the timeout.
                if (!w_own_req || w_hold_done) begin
                    w_state_nxt   = S_TURN;
                    w_en_nxt      = '0;
                    w_busy_nxt    = 1'b0;
                    w_last_nxt    = r_owner;
                    w_timeout_nxt = w_own_req;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the enables immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_en      <= '0;
            r_owner   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= OWN_W'(NREQ - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_en      <= w_en_nxt;
            r_owner   <= w_owner_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign o_en      = r_en;
    assign o_owner   = r_owner;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Testbench for bus_grant_ctrl: vector table, hand-written corner sequences,
// then random requests against a behavioural owner/queue model.
module tb_bus_grant_ctrl;

    localparam int NREQ     = 4;
    localparam int HOLD_MAX = 8;
    localparam int OWN_W    = 2;
`ifdef BUS_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  en;
    logic [OWN_W-1:0] owner;
    logic             busy;
    logic             tout;

    int n_tests = 0;
    int n_fail  = 0;

    bus_grant_ctrl #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX), .OWN_W(OWN_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .o_en      (en),
        .o_owner   (owner),
        .o_busy    (busy),
        .o_timeout (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  req;
        logic [NREQ-1:0]  en;
        logic             busy;
        logic [OWN_W-1:0] owner;
    } vec_t;

    vec_t tbl[27];

    // Model: who owns the bus (-1 = nobody), who owned it last, how long.
    int m_own, m_last, m_held;
    bit m_to;
    int wait_n[NREQ];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge: apply req, let one rising edge pass, return at negedge.
    task automatic step(logic [NREQ-1:0] rq);
        req = rq;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        #1;
        rst_n = 1'b1;
    endtask

    function automatic void m_reset();
        m_own  = -1;
        m_last = NREQ - 1;
        m_held = 0;
        m_to   = 1'b0;
    endfunction

    // One clock edge of the model with the request vector sampled at that edge.
    function automatic void m_step(logic [NREQ-1:0] rq);
        m_to = 1'b0;
        if (m_own >= 0) begin
            if (!rq[m_own]) begin
                m_last = m_own;
                m_own  = -1;
            end else if (TO_EN && m_held == HOLD_MAX) begin
                m_last = m_own;
                m_own  = -1;
                m_to   = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                int c;
                c = (m_last + i) % NREQ;
                if (rq[c]) begin
                    m_own  = c;
                    m_held = 1;
                    break;
                end
            end
        end
    endfunction

    initial begin
        logic [NREQ-1:0] rq;
        logic [NREQ-1:0] prev_en;
        logic [NREQ-1:0] exp_en;

        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
        tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[7]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{4'b1110, 4'b0000, 1'b0, 2'd0};
        tbl[9]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[10] = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{4'b1101, 4'b0000, 1'b0, 2'd0};
        tbl[12] = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[13] = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[14] = '{4'b1011, 4'b0000, 1'b0, 2'd0};
        tbl[15] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[16] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[17] = '{4'b0111, 4'b0000, 1'b0, 2'd0};
        tbl[18] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[19] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[20] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[21] = '{4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[22] = '{4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[23] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[24] = '{4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[25] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[26] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

        rst_n = 1'b0;
        req   = '0;
        #3;
        chk("reset_en",      32'(en),    0);
        chk("reset_busy",    32'(busy),  0);
        chk("reset_owner",   32'(owner), 0);
        chk("reset_timeout", 32'(tout),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, round robin, single-requester re-grant.
        for (int v = 0; v < 27; v++) begin
            step(tbl[v].req);
            chk($sformatf("tbl%0d_en", v),      32'(en),   32'(tbl[v].en));
            chk($sformatf("tbl%0d_busy", v),    32'(busy), 32'(tbl[v].busy));
            chk($sformatf("tbl%0d_timeout", v), 32'(tout), 0);
            if (tbl[v].busy)
                chk($sformatf("tbl%0d_owner", v), 32'(owner), 32'(tbl[v].owner));
        end

        // Async reset mid-grant, then req[0] has first priority.
        do_reset();
        @(negedge clk);
        step(4'b0010);
        chk("ar_pre_en", 32'(en), 32'(4'b0010));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_en",   32'(en),   0);
        chk("ar_async_busy", 32'(busy), 0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ar_first_en",    32'(en),    32'(4'b0001));
        chk("ar_first_owner", 32'(owner), 0);

`ifdef BUS_GRANT_TIMEOUT_EN
        // Forced release after HOLD_MAX cycles, alternating two holders.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < HOLD_MAX; k++) begin
            step(4'b0011);
            chk("to_own0_en", 32'(en), 32'(4'b0001));
            chk("to_own0_to", 32'(tout), 0);
        end
        step(4'b0011);
        chk("to_turn0_en", 32'(en), 0);
        chk("to_turn0_to", 32'(tout), 1);
        for (int k = 0; k < HOLD_MAX; k++) begin
            step(4'b0011);
            chk("to_own1_en", 32'(en), 32'(4'b0010));
            chk("to_own1_to", 32'(tout), 0);
        end
        step(4'b0011);
        chk("to_turn1_en", 32'(en), 0);
        chk("to_turn1_to", 32'(tout), 1);
        step(4'b0011);
        chk("to_back0_en", 32'(en), 32'(4'b0001));
`else
        // Without timeout the owner keeps the bus while its request is held.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            step(4'b0001);
            chk("hold_en", 32'(en), 32'(4'b0001));
            chk("hold_to", 32'(tout), 0);
        end
        step(4'b0000);
        chk("hold_rel_en", 32'(en), 0);
`endif

        // Random requests against the model plus structural invariants.
        do_reset();
        m_reset();
        @(negedge clk);
        rq      = '0;
        prev_en = '0;
        for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(5) == 0) rq[i] = ~rq[i];
            m_step(rq);
            step(rq);
            exp_en = (m_own >= 0) ? NREQ'(1) << m_own : '0;
            chk("rnd_en",      32'(en),   32'(exp_en));
            chk("rnd_busy",    32'(busy), 32'(m_own >= 0));
            chk("rnd_timeout", 32'(tout), 32'(m_to));
            if (m_own >= 0) chk("rnd_owner", 32'(owner), 32'(m_own));
            chk("rnd_onehot0", 32'($onehot0(en)), 1);
            chk("rnd_busy_or", 32'(busy), 32'(|en));
            chk("rnd_gap", 32'(prev_en != 0 && en != 0 && prev_en != en), 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i]) begin
                    wait_n[i] = 0;
                end else if (prev_en == 0 && en != 0) begin
                    if (en[i]) wait_n[i] = 0;
                    else       wait_n[i]++;
                    chk($sformatf("rnd_starve%0d", i), 32'(wait_n[i] > NREQ), 0);
                end
            end
            prev_en = en;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
